// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 4-digit 7-segment bus: synchronizes the pins,
// waits for each dwell to settle, decodes it and assembles one 16-bit value per scan.
module seg7_scan_decoder #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [3:0]  digit_en_i,
   input  logic [7:0]  seg_i,
   input  logic        clr_i,
   output logic [15:0] value_o,
   output logic [3:0]  dp_o,
   output logic [3:0]  invalid_o,
   output logic        frame_valid_o,
   output logic        overlap_err_o,
   output logic        stale_o
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

   // Returns {invalid, nibble}; unknown patterns decode to nibble 0.
   function automatic logic [4:0] dec7(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h3F:   r = 5'h00;
         7'h06:   r = 5'h01;
         7'h5B:   r = 5'h02;
         7'h4F:   r = 5'h03;
         7'h66:   r = 5'h04;
         7'h6D:   r = 5'h05;
         7'h7D:   r = 5'h06;
         7'h07:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h6F:   r = 5'h09;
         7'h77:   r = 5'h0A;
         7'h7C:   r = 5'h0B;
         7'h39:   r = 5'h0C;
         7'h5E:   r = 5'h0D;
         7'h79:   r = 5'h0E;
         7'h71:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   logic [3:0]    en_s1_q, en_s1_d, en_s2_q, en_s2_d;
   logic [7:0]    seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [11:0]   prev_q, prev_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic          capt_q, capt_d;
   logic [3:0]    mask_q, mask_d;
   logic [15:0]   sh_val_q, sh_val_d;
   logic [3:0]    sh_dp_q, sh_dp_d, sh_inv_q, sh_inv_d;
   logic [15:0]   val_q, val_d;
   logic [3:0]    dp_q, dp_d, inv_q, inv_d;
   logic          fv_q, fv_d, ovl_q, ovl_d, stale_q, stale_d;
   logic [TW-1:0] tcnt_q, tcnt_d;

   logic [7:0]  seg_w;
   logic [11:0] samp;
   logic        same, capture, multi, frame_done;
   logic [4:0]  dec;

   always_comb begin
      en_s1_d  = digit_en_i;
      en_s2_d  = en_s1_q;
      seg_s1_d = seg_i;
      seg_s2_d = seg_s1_q;

      seg_w  = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
      samp   = {en_s2_q, seg_w};
      same   = (samp == prev_q);
      prev_d = samp;

      if (!same)
         cnt_d = '0;
      else if (cnt_q == SET_MAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 1'b1;

      // One capture per dwell: the flag holds until the sample changes.
      capture = (cnt_d == SET_MAX) && !(same && capt_q);
      capt_d  = capture || (same && capt_q);

      multi      = (en_s2_q & (en_s2_q - 4'd1)) != 4'd0;
      dec        = dec7(seg_w[6:0]);
      frame_done = (mask_q == 4'hF);

      mask_d   = frame_done ? 4'h0 : mask_q;
      sh_val_d = sh_val_q;
      sh_dp_d  = sh_dp_q;
      sh_inv_d = sh_inv_q;
      if (capture && !multi) begin
         for (int i = 0; i < 4; i++) begin
            if (en_s2_q[i]) begin
               sh_val_d[4*i +: 4] = dec[3:0];
               sh_dp_d[i]         = seg_w[7];
               sh_inv_d[i]        = dec[4];
               mask_d[i]          = 1'b1;
            end
         end
      end

      fv_d  = frame_done;
      val_d = frame_done ? sh_val_q : val_q;
      dp_d  = frame_done ? sh_dp_q  : dp_q;
      inv_d = frame_done ? sh_inv_q : inv_q;

      if (frame_done)
         tcnt_d = '0;
      else if (tcnt_q == TMO_MAX)
         tcnt_d = tcnt_q;
      else
         tcnt_d = tcnt_q + 1'b1;

      ovl_d = (capture && multi) || (!clr_i && ovl_q);
      if (!frame_done && tcnt_d == TMO_MAX)
         stale_d = 1'b1;
      else if (frame_done || clr_i)
         stale_d = 1'b0;
      else
         stale_d = stale_q;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         en_s1_q  <= '0;
         en_s2_q  <= '0;
         seg_s1_q <= '0;
         seg_s2_q <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         capt_q   <= 1'b0;
         mask_q   <= '0;
         sh_val_q <= '0;
         sh_dp_q  <= '0;
         sh_inv_q <= '0;
         val_q    <= '0;
         dp_q     <= '0;
         inv_q    <= '0;
         fv_q     <= 1'b0;
         ovl_q    <= 1'b0;
         stale_q  <= 1'b0;
         tcnt_q   <= '0;
      end else begin
         en_s1_q  <= en_s1_d;
         en_s2_q  <= en_s2_d;
         seg_s1_q <= seg_s1_d;
         seg_s2_q <= seg_s2_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         capt_q   <= capt_d;
         mask_q   <= mask_d;
         sh_val_q <= sh_val_d;
         sh_dp_q  <= sh_dp_d;
         sh_inv_q <= sh_inv_d;
         val_q    <= val_d;
         dp_q     <= dp_d;
         inv_q    <= inv_d;
         fv_q     <= fv_d;
         ovl_q    <= ovl_d;
         stale_q  <= stale_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign value_o       = val_q;
   assign dp_o          = dp_q;
   assign invalid_o     = inv_q;
   assign frame_valid_o = fv_q;
   assign overlap_err_o = ovl_q;
   assign stale_o       = stale_q;

endmodule
